// File: rtl/microwave_pkg.sv
// Shared types and constants for the microwave countdown timer.
//   state_t : controller state of the timer FSM
//   bcd_t   : one BCD digit
//   mmss_t  : displayed time {m1,m0,s1,s0}
package microwave_pkg;

  typedef enum logic [2:0] {IDLE, ARMED, RUN, HOLD, DONE} state_t;

  typedef logic [3:0] bcd_t;

  typedef struct packed {
    bcd_t m1;
    bcd_t m0;
    bcd_t s1;
    bcd_t s0;
  } mmss_t;

  localparam mmss_t QUICK_TIME = 16'h0030;
  localparam mmss_t MAX_TIME   = 16'h9959;

  // BCD minutes + 1; bit 8 flags overflow past 99.
  function automatic logic [8:0] mins_inc(input bcd_t m1, input bcd_t m0);
    logic [8:0] r;
    if (m0 != 4'd9)      r = {1'b0, m1, m0 + 4'd1};
    else if (m1 != 4'd9) r = {1'b0, m1 + 4'd1, 4'd0};
    else                 r = {1'b1, 4'd9, 4'd9};
    return r;
  endfunction

endpackage

// File: rtl/bcd_mmss_arith.sv
// Combinational mm:ss BCD arithmetic for the microwave timer.
//   i_time        : time for decrement / normalise / zero tests
//   i_add_src     : time that receives +30 s (saturating at 99:59)
//   o_dec         : i_time minus one second
//   o_add30       : i_add_src plus 30 s, saturated
//   o_norm        : i_time with seconds tens >5 folded into minutes
//   o_is_zero     : i_time == 00:00
//   o_dec_is_zero : o_dec == 00:00
module bcd_mmss_arith
  import microwave_pkg::*;
(
  input  mmss_t i_time,
  input  mmss_t i_add_src,
  output mmss_t o_dec,
  output mmss_t o_add30,
  output mmss_t o_norm,
  output logic  o_is_zero,
  output logic  o_dec_is_zero
);

  logic [3:0] w_s1_sum;
  logic [8:0] w_add_min;
  logic [8:0] w_norm_min;

  always_comb begin
    o_dec = i_time;
    if (i_time.s0 != 4'd0) begin
      o_dec.s0 = i_time.s0 - 4'd1;
    end else begin
      o_dec.s0 = 4'd9;
      if (i_time.s1 != 4'd0) begin
        o_dec.s1 = i_time.s1 - 4'd1;
      end else begin
        o_dec.s1 = 4'd5;
        if (i_time.m0 != 4'd0) begin
          o_dec.m0 = i_time.m0 - 4'd1;
        end else begin
          o_dec.m0 = 4'd9;
          o_dec.m1 = i_time.m1 - 4'd1;
        end
      end
    end
  end

  // Seconds tens is at most 5 here, so s1+3 fits and one carry suffices.
  always_comb begin
    o_add30   = i_add_src;
    w_s1_sum  = i_add_src.s1 + 4'd3;
    w_add_min = mins_inc(i_add_src.m1, i_add_src.m0);
    if (w_s1_sum >= 4'd6) begin
      if (w_add_min[8]) begin
        o_add30 = MAX_TIME;
      end else begin
        o_add30.m1 = w_add_min[7:4];
        o_add30.m0 = w_add_min[3:0];
        o_add30.s1 = w_s1_sum - 4'd6;
      end
    end else begin
      o_add30.s1 = w_s1_sum;
    end
  end

  always_comb begin
    o_norm     = i_time;
    w_norm_min = mins_inc(i_time.m1, i_time.m0);
    if (i_time.s1 > 4'd5) begin
      if (w_norm_min[8]) begin
        o_norm = MAX_TIME;
      end else begin
        o_norm.m1 = w_norm_min[7:4];
        o_norm.m0 = w_norm_min[3:0];
        o_norm.s1 = i_time.s1 - 4'd6;
      end
    end
  end

  assign o_is_zero     = (i_time == '0);
  assign o_dec_is_zero = (o_dec == '0);

endmodule

// File: rtl/microwave_timer.sv
// Time-entry and countdown unit in front of the microwave door/heat controller.
//   clk, nrst          : clock, asynchronous active-low reset
//   key_valid/digit    : digit strobe and BCD digit (10..15 ignored)
//   key_start          : start / +30 s key strobe
//   key_clear          : clear / stop key strobe
//   heat, bell         : controller status
//   start              : one-cycle start pulse to controller
//   finish             : countdown reached zero (held until bell/clear)
//   running            : high while counting
//   remaining          : BCD {m1,m0,s1,s0} display time
module microwave_timer
  import microwave_pkg::*;
#(
  parameter int unsigned TICK_DIV = 50_000_000
)
(
  input  logic        clk,
  input  logic        nrst,
  input  logic        key_valid,
  input  logic [3:0]  key_digit,
  input  logic        key_start,
  input  logic        key_clear,
  input  logic        heat,
  input  logic        bell,
  output logic        start,
  output logic        finish,
  output logic        running,
  output logic [15:0] remaining
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

  state_t        r_state, w_state_nxt;
  mmss_t         r_rem, w_rem_nxt;
  logic [PW-1:0] r_presc, w_presc_nxt;
  logic          r_start, r_finish, r_running, w_start_nxt;

  logic  w_tick;
  mmss_t w_add_src, w_dec, w_add30, w_norm;
  logic  w_is_zero, w_dec_is_zero;

  assign w_tick    = (r_state == RUN) && heat && (r_presc == TICK_LAST);
  // A tick coinciding with +30 adds to the already-decremented time.
  assign w_add_src = w_tick ? w_dec : r_rem;

  bcd_mmss_arith u_arith (
    .i_time        (r_rem),
    .i_add_src     (w_add_src),
    .o_dec         (w_dec),
    .o_add30       (w_add30),
    .o_norm        (w_norm),
    .o_is_zero     (w_is_zero),
    .o_dec_is_zero (w_dec_is_zero)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_rem_nxt   = r_rem;
    w_presc_nxt = r_presc;
    w_start_nxt = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (key_clear) begin
          w_rem_nxt = '0;
        end else if (key_start) begin
          w_rem_nxt   = w_is_zero ? QUICK_TIME : w_norm;
          w_start_nxt = 1'b1;
          w_state_nxt = ARMED;
        end else if (key_valid && (key_digit <= 4'd9)) begin
          w_rem_nxt = {r_rem.m0, r_rem.s1, r_rem.s0, key_digit};
        end
      end
      ARMED: begin
        if (key_clear) begin
          w_rem_nxt   = '0;
          w_state_nxt = IDLE;
        end else if (heat) begin
          w_presc_nxt = '0;
          w_state_nxt = RUN;
        end else if (key_start) begin
          w_start_nxt = 1'b1;
        end
      end
      RUN: begin
        if (key_clear) begin
          w_rem_nxt   = '0;
          w_state_nxt = DONE;
        end else begin
          if (heat) w_presc_nxt = w_tick ? '0 : r_presc + PW'(1);
          if (key_start) begin
            w_rem_nxt = w_add30;
          end else if (w_tick) begin
            w_rem_nxt = w_dec;
            if (w_dec_is_zero) w_state_nxt = DONE;
          end
          if (!heat) w_state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (key_clear) begin
          w_rem_nxt   = '0;
          w_state_nxt = DONE;
        end else begin
          if (key_start) w_rem_nxt = w_add30;
          if (heat) w_state_nxt = RUN;
        end
      end
      DONE: begin
        if (key_clear || bell) w_state_nxt = IDLE;
      end
      default: begin
        w_rem_nxt   = '0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state   <= IDLE;
      r_rem     <= '0;
      r_presc   <= '0;
      r_start   <= 1'b0;
      r_finish  <= 1'b0;
      r_running <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_rem     <= w_rem_nxt;
      r_presc   <= w_presc_nxt;
      r_start   <= w_start_nxt;
      r_finish  <= (w_state_nxt == DONE);
      r_running <= (w_state_nxt == RUN);
    end
  end

  assign start     = r_start;
  assign finish    = r_finish;
  assign running   = r_running;
  assign remaining = r_rem;

endmodule

// File: tb/tb_microwave_timer.sv
module tb_microwave_timer;

  localparam int TD = 4;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        key_valid = 1'b0;
  logic [3:0]  key_digit = 4'd0;
  logic        key_start = 1'b0;
  logic        key_clear = 1'b0;
  logic        heat = 1'b0;
  logic        bell = 1'b0;
  logic        start, finish, running;
  logic [15:0] remaining;

  int checks = 0;
  int errors = 0;

  microwave_timer #(.TICK_DIV(TD)) dut (
    .clk       (clk),
    .nrst      (nrst),
    .key_valid (key_valid),
    .key_digit (key_digit),
    .key_start (key_start),
    .key_clear (key_clear),
    .heat      (heat),
    .bell      (bell),
    .start     (start),
    .finish    (finish),
    .running   (running),
    .remaining (remaining)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
    end
  endfunction

  // Reference model: time kept as plain seconds, digits as an array in entry mode.
  localparam int MI = 0, MA = 1, MR = 2, MH = 3, MD = 4;
  int         mode = MI;
  int         secs = 0;
  int         phase = 0;
  logic [3:0] dig [4] = '{4'd0, 4'd0, 4'd0, 4'd0};
  logic       m_start = 1'b0;

  function automatic int clamp(input int t);
    return (t > 5999) ? 5999 : t;
  endfunction

  function automatic logic [15:0] bcd_of(input int t);
    int m, s;
    m = t / 60;
    s = t % 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic logic [15:0] model_rem();
    if (mode == MI) return {dig[0], dig[1], dig[2], dig[3]};
    return bcd_of(secs);
  endfunction

  function automatic void clear_digits();
    for (int i = 0; i < 4; i++) dig[i] = 4'd0;
  endfunction

  function automatic void model_reset();
    mode = MI; secs = 0; phase = 0; m_start = 1'b0;
    clear_digits();
  endfunction

  function automatic void model_step();
    bit tick;
    int entered;
    m_start = 1'b0;
    case (mode)
      MI: begin
        if (key_clear) clear_digits();
        else if (key_start) begin
          entered = (int'(dig[0]) * 10 + int'(dig[1])) * 60 + int'(dig[2]) * 10 + int'(dig[3]);
          secs = (entered == 0) ? 30 : clamp(entered);
          m_start = 1'b1;
          mode = MA;
        end else if (key_valid && key_digit <= 4'd9) begin
          dig[0] = dig[1]; dig[1] = dig[2]; dig[2] = dig[3]; dig[3] = key_digit;
        end
      end
      MA: begin
        if (key_clear) begin mode = MI; clear_digits(); end
        else if (heat) begin mode = MR; phase = 0; end
        else if (key_start) m_start = 1'b1;
      end
      MR: begin
        if (key_clear) begin mode = MD; secs = 0; end
        else begin
          tick = heat && (phase == TD - 1);
          if (heat) phase = (phase + 1) % TD;
          if (tick) secs = secs - 1;
          if (key_start) secs = clamp(secs + 30);
          else if (tick && secs == 0) mode = MD;
          if (mode == MR && !heat) mode = MH;
        end
      end
      MH: begin
        if (key_clear) begin mode = MD; secs = 0; end
        else begin
          if (key_start) secs = clamp(secs + 30);
          if (heat) mode = MR;
        end
      end
      MD: begin
        if (key_clear || bell) begin mode = MI; secs = 0; clear_digits(); end
      end
      default: model_reset();
    endcase
  endfunction

  always @(posedge clk) begin
    if (!nrst) model_reset();
    else model_step();
    #1;
    check("m_remaining", remaining, model_rem());
    check("m_start", 16'(start), 16'(m_start));
    check("m_finish", 16'(finish), 16'(mode == MD));
    check("m_running", 16'(running), 16'(mode == MR));
  end

  task automatic press_digit(input int d);
    key_valid = 1'b1; key_digit = 4'(d);
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic press_start();
    key_start = 1'b1;
    @(negedge clk);
    key_start = 1'b0;
  endtask

  task automatic press_clear();
    key_clear = 1'b1;
    @(negedge clk);
    key_clear = 1'b0;
  endtask

  task automatic pulse_bell();
    bell = 1'b1;
    @(negedge clk);
    bell = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    check("pin_norm", bcd_of(clamp(90)), 16'h0130);
    check("pin_add", bcd_of(clamp(45 + 30)), 16'h0115);
    check("pin_sat", bcd_of(clamp(99 * 60 + 45 + 30)), 16'h9959);
    check("pin_dec", bcd_of(60 - 1), 16'h0059);

    wait_cyc(2);
    check("reset_rem", remaining, 16'h0000);
    check("reset_flags", 16'({start, finish, running}), 16'h0000);
    nrst = 1'b1;
    @(negedge clk);

    press_digit(1); press_digit(2); press_digit(0); press_digit(5);
    check("entry_idle", remaining, 16'h1205);
    press_start();
    check("entry_rem", remaining, 16'h1205);
    check("entry_start", 16'(start), 16'h0001);
    @(negedge clk);
    check("start_single", 16'(start), 16'h0000);
    heat = 1'b1;
    @(negedge clk);
    check("entry_running", 16'(running), 16'h0001);
    press_clear();
    check("clear_run_rem", remaining, 16'h0000);
    check("clear_run_finish", 16'(finish), 16'h0001);
    heat = 1'b0;
    pulse_bell();
    check("bell_finish_drop", 16'(finish), 16'h0000);

    press_digit(0); press_digit(2);
    press_start();
    heat = 1'b1;
    @(negedge clk);
    check("cd_running", 16'(running), 16'h0001);
    wait_cyc(4);
    check("cd_0001", remaining, 16'h0001);
    wait_cyc(4);
    check("cd_0000", remaining, 16'h0000);
    check("cd_finish", 16'(finish), 16'h0001);
    pulse_bell();
    check("cd_bell_finish", 16'(finish), 16'h0000);
    check("cd_bell_running", 16'(running), 16'h0000);
    heat = 1'b0;

    press_start();
    check("quick_rem", remaining, 16'h0030);
    check("quick_start", 16'(start), 16'h0001);
    press_clear();
    check("armed_clear", remaining, 16'h0000);

    press_digit(9); press_digit(0);
    press_start();
    check("norm_0130", remaining, 16'h0130);
    press_clear();

    press_digit(1); press_digit(0); press_digit(0);
    press_start();
    heat = 1'b1;
    @(negedge clk);
    wait_cyc(4);
    check("borrow_0059", remaining, 16'h0059);
    wait_cyc(2);
    heat = 1'b0;
    wait_cyc(20);
    check("pause_frozen", remaining, 16'h0059);
    check("pause_running", 16'(running), 16'h0000);
    heat = 1'b1;
    wait_cyc(2);
    check("resume_pre", remaining, 16'h0059);
    wait_cyc(1);
    check("resume_tick", remaining, 16'h0058);
    heat = 1'b0;
    press_clear();
    press_clear();

    press_digit(4); press_digit(5);
    press_start();
    heat = 1'b1;
    @(negedge clk);
    heat = 1'b0;
    @(negedge clk);
    press_start();
    check("hold_add_0115", remaining, 16'h0115);
    check("hold_running", 16'(running), 16'h0000);
    press_clear();
    check("hold_clear_finish", 16'(finish), 16'h0001);
    press_clear();

    press_digit(9); press_digit(9); press_digit(4); press_digit(5);
    press_start();
    heat = 1'b1;
    @(negedge clk);
    press_start();
    check("sat_9959", remaining, 16'h9959);
    check("sat_running", 16'(running), 16'h0001);
    press_clear();
    press_clear();

    press_digit(0); press_digit(1);
    press_start();
    @(negedge clk);
    wait_cyc(3);
    press_start();
    check("tick_add_0030", remaining, 16'h0030);
    check("tick_add_running", 16'(running), 16'h0001);
    press_clear();
    press_clear();

    press_digit(3); press_digit(0); press_digit(0);
    press_start();
    @(negedge clk);
    check("run_0300", remaining, 16'h0300);
    press_clear();
    check("clr_0300_rem", remaining, 16'h0000);
    check("clr_0300_finish", 16'(finish), 16'h0001);
    pulse_bell();

    press_digit(5);
    press_start();
    @(negedge clk);
    wait_cyc(2);
    #2 nrst = 1'b0;
    #1;
    check("async_rst_rem", remaining, 16'h0000);
    check("async_rst_flags", 16'({start, finish, running}), 16'h0000);
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    check("post_rst_rem", remaining, 16'h0000);
    check("post_rst_running", 16'(running), 16'h0000);
    heat = 1'b0;

    for (int i = 0; i < 4000; i++) begin
      key_valid = ($urandom_range(0, 99) < 30);
      key_digit = 4'($urandom_range(0, 15));
      key_start = ($urandom_range(0, 99) < 3);
      key_clear = ($urandom_range(0, 199) < 2);
      if ($urandom_range(0, 99) < 6) heat = ~heat;
      bell = ($urandom_range(0, 99) < 8);
      nrst = ($urandom_range(0, 999) != 0);
      @(negedge clk);
    end
    key_valid = 1'b0; key_start = 1'b0; key_clear = 1'b0; bell = 1'b0; nrst = 1'b1;
    wait_cyc(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
